// File: rtl/dmem_resp.sv
// Data-memory access controller: one outstanding load/store, word bus with byte
// enables, ack/err/timeout completion, aligned and extended load result.
module dmem_resp #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic        req_zero_ext,
  input  logic [31:0] req_st_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_ld_data,
  output logic        rsp_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_rd, w_rd_nxt;
  logic [1:0]    r_off, w_off_nxt;
  logic [2:0]    r_size, w_size_nxt;
  logic          r_zext, w_zext_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_req_ready, w_req_ready_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]   r_rsp_ld_data, w_rsp_ld_data_nxt;
  logic          r_rsp_fault, w_rsp_fault_nxt;
  logic          r_mem_req, w_mem_req_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [31:0]   r_mem_addr, w_mem_addr_nxt;
  logic [3:0]    r_mem_be, w_mem_be_nxt;
  logic [31:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic          w_bad;

  // Select the addressed lane(s) of the read word and extend to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [2:0] size, input logic zext);
    logic [31:0] s;
    s = rdata >> {off, 3'b000};
    case (size)
      3'd1:    fmt_load = {{24{~zext & s[7]}}, s[7:0]};
      3'd2:    fmt_load = {{16{~zext & s[15]}}, s[15:0]};
      default: fmt_load = rdata;
    endcase
  endfunction

  always_comb begin
    w_state_nxt       = r_state;
    w_rd_nxt          = r_rd;
    w_off_nxt         = r_off;
    w_size_nxt        = r_size;
    w_zext_nxt        = r_zext;
    w_timer_nxt       = r_timer;
    w_req_ready_nxt   = r_req_ready;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_ld_data_nxt = r_rsp_ld_data;
    w_rsp_fault_nxt   = r_rsp_fault;
    w_mem_req_nxt     = r_mem_req;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_be_nxt      = r_mem_be;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_bad = ((req_size == 3'd2) && req_addr[0]) ||
            ((req_size == 3'd4) && (req_addr[1:0] != 2'b00)) ||
            !((req_size == 3'd1) || (req_size == 3'd2) || (req_size == 3'd4));
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_rd_nxt        = req_rd;
          w_off_nxt       = req_addr[1:0];
          w_size_nxt      = req_size;
          w_zext_nxt      = req_zero_ext;
          w_req_ready_nxt = 1'b0;
          if (w_bad) begin
            w_state_nxt       = S_RESP;
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_fault_nxt   = 1'b1;
            w_rsp_ld_data_nxt = 32'h0;
          end else begin
            w_state_nxt    = S_BUS;
            w_timer_nxt    = '0;
            w_mem_req_nxt  = 1'b1;
            w_mem_we_nxt   = ~req_rd;
            w_mem_addr_nxt = {req_addr[31:2], 2'b00};
            case (req_size)
              3'd1: begin
                w_mem_be_nxt    = 4'b0001 << req_addr[1:0];
                w_mem_wdata_nxt = {4{req_st_data[7:0]}};
              end
              3'd2: begin
                w_mem_be_nxt    = 4'b0011 << req_addr[1:0];
                w_mem_wdata_nxt = {2{req_st_data[15:0]}};
              end
              default: begin
                w_mem_be_nxt    = 4'b1111;
                w_mem_wdata_nxt = req_st_data;
              end
            endcase
          end
        end
      end
      S_BUS: begin
        // Error beats ack, and both beat an expiring timer.
        if (mem_err || mem_ack || ((TIMEOUT != 0) && (r_timer == TLAST))) begin
          w_state_nxt       = S_RESP;
          w_mem_req_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_fault_nxt   = mem_err | ~mem_ack;
          w_rsp_ld_data_nxt = (!mem_err && mem_ack && r_rd) ?
                              fmt_load(mem_rdata, r_off, r_size, r_zext) : 32'h0;
        end else if (r_timer != '1) begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state       <= S_IDLE;
      r_rd          <= 1'b0;
      r_off         <= 2'b00;
      r_size        <= 3'd0;
      r_zext        <= 1'b0;
      r_timer       <= '0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_ld_data <= 32'h0;
      r_rsp_fault   <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_be      <= 4'h0;
      r_mem_wdata   <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd          <= w_rd_nxt;
      r_off         <= w_off_nxt;
      r_size        <= w_size_nxt;
      r_zext        <= w_zext_nxt;
      r_timer       <= w_timer_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_ld_data <= w_rsp_ld_data_nxt;
      r_rsp_fault   <= w_rsp_fault_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_be      <= w_mem_be_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_ld_data = r_rsp_ld_data;
  assign rsp_fault   = r_rsp_fault;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_be      = r_mem_be;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory access controller sitting between the EXE-stage load/store functional unit and the data bus. Accepts one formatted load/store request (address, size, zero-extend flag, store data), drives a word-wide memory bus with byte enables, waits for acknowledge, error or timeout, and returns the aligned, sign- or zero-extended load result or a fault to the MEM stage. One access is outstanding at a time.

## Interface
- TIMEOUT, 255: bus cycles to wait for mem_ack/mem_err before faulting; 0 disables the timeout.
- clk_in  in  1  single clock, all state on rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (state IDLE).
- req_rd  in  1  1 = load, 0 = store.
- req_addr  in  32  byte address.
- req_size  in  3  access size in bytes: 1, 2 or 4.
- req_zero_ext  in  1  1 = LBU/LHU zero extension, 0 = sign extension.
- req_st_data  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  MEM stage accepts response.
- rsp_ld_data  out  32  formatted load data; 0 for stores and faults.
- rsp_fault  out  1  access fault (bus error, timeout, misaligned or illegal size).
- mem_req  out  1  bus request, held until ack/err/timeout.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {req_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completes access; mem_rdata valid this cycle.
- mem_rdata  in  32  read data word.
- mem_err  in  1  bus error completion.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid & req_ready, latch all req_* fields. If misaligned (size 2 with addr[0]=1, size 4 with addr[1:0]≠0) or size ∉ {1,2,4}: go to RESP with fault=1, no bus cycle. Otherwise go to BUS, clear timer.
- BUS: mem_req=1, mem_we=~rd, mem_addr/mem_be/mem_wdata stable from latched fields. Each cycle: mem_err → fault=1, RESP; else mem_ack → capture mem_rdata, fault=0, RESP; else if TIMEOUT≠0 and timer==TIMEOUT-1 → fault=1, RESP; else timer++.
- RESP: rsp_valid=1, rsp_ld_data/rsp_fault stable until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
- Byte enables (o=addr[1:0]): size 1 → 4'b0001<<o; size 2 → 4'b0011<<o; size 4 → 4'b1111.
- Write data: size 1 → {4{st[7:0]}}; size 2 → {2{st[15:0]}}; size 4 → st.
- Load format: s = rdata >> (8*o); size 1 → ext(s[7:0]); size 2 → ext(s[15:0]); size 4 → rdata. ext = zero-fill if zero_ext else replicate MSB.
- Timer width clog2(TIMEOUT+1), never wraps.
- mem_ack/mem_err outside BUS ignored.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_ld_data=0, rsp_fault=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, timer=0. All bus outputs registered.
- Request accepted in cycle 0 → mem_req high from cycle 1.
- Ack in cycle k (k≥1) → rsp_valid from cycle k+1; minimum latency 2 cycles accept-to-response.
- Faulted-by-check requests: rsp_valid in cycle 1, mem_req never asserted.
- Timeout: mem_req high for exactly TIMEOUT cycles, rsp_valid on the next cycle.
- Simultaneous mem_ack & mem_err: err wins. Ack/err on the timeout cycle: ack/err wins over timeout.
- rsp_ready low: response held indefinitely; req_ready stays 0 (no back-to-back overlap).
- Back-to-back: rsp handshake in cycle n → req_ready=1 in cycle n+1.
- reset_in mid-BUS/RESP: immediate return to reset values; mem_req drops asynchronously, pending response discarded.

## Test plan
- LB addr 0x103, rdata 0x80AABBCC, ack 1 cycle after mem_req → mem_be=4'b1000, rsp_ld_data=0xFFFFFF80, fault=0, rsp_valid at cycle 2.
- LHU addr 0x202, rdata 0x8001_1234 → mem_be=4'b1100, rsp_ld_data=0x00008001; same with LH → 0xFFFF8001.
- SB addr 0x301 data 0x123456A5 → mem_we=1, mem_be=4'b0010, mem_wdata=0xA5A5A5A5, rsp_ld_data=0; SW addr 0x300 → be=4'b1111, wdata=0x123456A5.
- LW addr 0x402 → no mem_req, rsp_valid cycle 1, rsp_fault=1; req_size=3 → same.
- TIMEOUT=4, no ack → mem_req high 4 cycles, rsp_fault=1; ack and err together → rsp_fault=1.
- rsp_ready low 5 cycles → rsp_valid/data stable, req_ready=0; assert reset_in while in BUS → mem_req=0 same cycle, req_ready=1, later stray mem_ack ignored.
